// File: rtl/alu4_op_sequencer.sv
// Nibble-serial operand loader, settle timer and result holder around a combinational 4-bit ALU.
// Optional accumulator chaining is enabled by defining ALU4_CHAIN_EN.
module alu4_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       nib_in,
  input  logic             nib_valid,
  output logic             nib_ready,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_op,
  input  logic [3:0]       alu_out,
  input  logic             alu_z,
  input  logic             alu_c,
  output logic [3:0]       res_out,
  output logic             res_z,
  output logic             res_c,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // Counter preload: reaching zero marks the capture cycle.
  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] exec_cnt;
  logic       xfer;
  logic       ack_take;

  // Handshake: a nibble moves on any cycle with nib_valid & nib_ready; the producer may
  // stall indefinitely with nib_valid low. res_valid stays high until res_ack is sampled
  // in HOLD, and a level-high ack retires only the result currently held.
  assign xfer     = nib_valid & nib_ready;
  assign ack_take = (state == HOLD) & res_ack;

  always_comb begin
    state_nxt = state;
    nib_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD_A: begin
        nib_ready = 1'b1;
        if (xfer) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        nib_ready = 1'b1;
        if (xfer) state_nxt = LOAD_OP;
      end
      LOAD_OP: begin
        nib_ready = 1'b1;
        if (xfer) state_nxt = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (exec_cnt == 4'd0) state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
`ifdef ALU4_CHAIN_EN
        if (res_ack) state_nxt = LOAD_B;
`else
        if (res_ack) state_nxt = LOAD_A;
`endif
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= LOAD_A;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 4'd0;
      exec_cnt  <= 4'd0;
      res_out   <= 4'd0;
      res_z     <= 1'b0;
      res_c     <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      if (xfer && state == LOAD_A) alu_a <= nib_in;
      if (xfer && state == LOAD_B) alu_b <= nib_in;
      if (xfer && state == LOAD_OP) begin
        alu_op   <= nib_in;
        exec_cnt <= EXEC_INIT;
      end
      if (state == EXEC) begin
        if (exec_cnt == 4'd0) begin
          res_out   <= alu_out;
          res_z     <= alu_z;
          res_c     <= alu_c;
          res_valid <= 1'b1;
        end else begin
          exec_cnt <= exec_cnt - 4'd1;
        end
      end
      if (ack_take) begin
        res_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
`ifdef ALU4_CHAIN_EN
        // The held result becomes the next A operand.
        alu_a     <= res_out;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu4_op_sequencer.sv
// Bench for alu4_op_sequencer: one default instance and one with EXEC_CYCLES=4, CNT_W=2,
// each attached to a small ALU model; a select steers the shared driver to one instance.
module tb_alu4_op_sequencer;

`ifdef ALU4_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] nib_in = 4'd0;
  logic       nib_valid = 1'b0;
  logic       res_ack = 1'b0;
  logic       sel = 1'b0;

  logic [3:0] a0, b0, op0, ao0, ro0, a1, b1, op1, ao1, ro1;
  logic       r0, z0, c0, rz0, rc0, rv0, bz0, r1, z1, c1, rz1, rc1, rv1, bz1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [4:0] s;
    logic       c;
    logic [3:0] o;
    c = 1'b0;
    case (op)
      4'd4:  begin s = {1'b0, a} + {1'b0, b}; o = s[3:0]; c = s[4]; end
      4'd5:  begin o = a - b; c = (a < b); end
      4'd8:  o = a & b;
      4'd9:  o = a | b;
      4'd10: o = a ^ b;
      default: o = a;
    endcase
    return {c, (o == 4'd0), o};
  endfunction

  assign {c0, z0, ao0} = alu_f(a0, b0, op0);
  assign {c1, z1, ao1} = alu_f(a1, b1, op1);

  alu4_op_sequencer #(.EXEC_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .nib_in(nib_in), .nib_valid(nib_valid & ~sel), .nib_ready(r0),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_out(ao0), .alu_z(z0), .alu_c(c0),
    .res_out(ro0), .res_z(rz0), .res_c(rc0), .res_valid(rv0), .res_ack(res_ack & ~sel),
    .busy(bz0), .op_count(cnt0)
  );

  alu4_op_sequencer #(.EXEC_CYCLES(4), .CNT_W(2)) dut4 (
    .clk(clk), .resetn(resetn), .nib_in(nib_in), .nib_valid(nib_valid & sel), .nib_ready(r1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_out(ao1), .alu_z(z1), .alu_c(c1),
    .res_out(ro1), .res_z(rz1), .res_c(rc1), .res_valid(rv1), .res_ack(res_ack & sel),
    .busy(bz1), .op_count(cnt1)
  );

  wire [3:0] cur_a     = sel ? a1  : a0;
  wire [3:0] cur_b     = sel ? b1  : b0;
  wire [3:0] cur_op    = sel ? op1 : op0;
  wire [3:0] cur_out   = sel ? ro1 : ro0;
  wire       cur_z     = sel ? rz1 : rz0;
  wire       cur_c     = sel ? rc1 : rc0;
  wire       cur_valid = sel ? rv1 : rv0;
  wire       cur_ready = sel ? r1  : r0;
  wire       cur_busy  = sel ? bz1 : bz0;
  wire [7:0] cur_cnt   = sel ? {6'd0, cnt1} : cnt0;

  typedef struct {
    logic       sel;
    logic [3:0] a, b, op, out;
    logic       z, c;
    int         mode;  // 0: ack pulse, 1: ack held high
  } vec_t;

  vec_t       vecs[12];
  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_cnt[2];
  bit         chain_live[2];
  bit         stall_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send_nib(input logic [3:0] v);
    int g;
    int n;
    g = 0;
    if (stall_en) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        nib_valid = 1'b0;
        nib_in    = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
    end
    nib_in    = v;
    nib_valid = 1'b1;
    while (!cur_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!cur_ready) check("nib_accept_timeout", 0, 1);
    @(negedge clk);
    nib_valid = 1'b0;
  endtask

  task automatic cnt_check(input string nm);
    check(nm, int'(cur_cnt), exp_cnt[sel] % (sel ? 4 : 256));
  endtask

  // mode 0: pulse ack after probing HOLD; 1: ack already held high; 2: stay in HOLD
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] eo, input logic ez, input logic ec, input int mode);
    int k;
    logic [5:0] got;
    logic [5:0] exp;
    if (chain_live[sel]) check("chain_a", int'(cur_a), int'(a));
    else                 send_nib(a);
    send_nib(b);
    send_nib(op);
    exp_q.push_back({ec, ez, eo});
    check("ready_exec", int'(cur_ready), 0);
    check("busy_exec", int'(cur_busy), 1);
    check("alu_a", int'(cur_a), int'(a));
    check("alu_b", int'(cur_b), int'(b));
    check("alu_op", int'(cur_op), int'(op));
    k = 0;
    while (!cur_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, sel ? 4 : 1);
    if (cur_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        got = {cur_c, cur_z, cur_out};
        check("result_czo", int'(got), int'(exp));
      end
    end
    if (mode == 0) begin
      nib_in    = 4'h7;
      nib_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("hold_ready", int'(cur_ready), 0);
      check("hold_valid", int'(cur_valid), 1);
      check("hold_out", int'(cur_out), int'(eo));
      check("hold_a_kept", int'(cur_a), int'(a));
      nib_valid = 1'b0;
      res_ack   = 1'b1;
      @(negedge clk);
      res_ack   = 1'b0;
    end else if (mode == 1) begin
      @(negedge clk);
    end
    if (mode != 2) begin
      exp_cnt[sel]++;
      chain_live[sel] = CHAIN;
      check("valid_after_ack", int'(cur_valid), 0);
      check("ready_after_ack", int'(cur_ready), 1);
      check("busy_after_ack", int'(cur_busy), 0);
      check("a_after_ack", int'(cur_a), CHAIN ? int'(eo) : int'(a));
      cnt_check("op_count");
    end
  endtask

  task automatic run_vec(input int i);
    sel = vecs[i].sel;
    if (vecs[i].mode == 1) res_ack = 1'b1;
    run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].out, vecs[i].z, vecs[i].c, vecs[i].mode);
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check({nm, "_valid"}, int'(cur_valid), 0);
    check({nm, "_cnt"}, int'(cur_cnt), 0);
    check({nm, "_regs"}, int'({cur_a, cur_b, cur_op, cur_out}), 0);
    check({nm, "_flags"}, int'({cur_z, cur_c, cur_busy}), 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    chain_live[0] = 1'b0;
    chain_live[1] = 1'b0;
    @(negedge clk);
    check({nm, "_ready"}, int'(cur_ready), 1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h3, 4'h2, 4'd4,  4'h5, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 4'h5, 4'hB, 4'd4,  4'h0, 1'b1, 1'b1, 0};
    vecs[2]  = '{1'b0, 4'h0, 4'hF, 4'd9,  4'hF, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 4'd10, 4'h0, 1'b1, 1'b0, 0};
    vecs[4]  = '{1'b0, 4'h0, 4'h3, 4'd5,  4'hD, 1'b0, 1'b1, 0};
    vecs[5]  = '{1'b0, 4'hD, 4'h6, 4'd8,  4'h4, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 4'h4, 4'h4, 4'd4,  4'h8, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 4'h8, 4'h8, 4'd4,  4'h0, 1'b1, 1'b1, 1};
    vecs[8]  = '{1'b1, 4'hF, 4'h0, 4'd8,  4'h0, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b1, 4'h0, 4'h1, 4'd4,  4'h1, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b1, 4'h1, 4'h1, 4'd4,  4'h2, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b1, 4'h2, 4'h3, 4'd4,  4'h5, 1'b0, 1'b0, 0};
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    chain_live[0] = 1'b0;
    chain_live[1] = 1'b0;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_regs", int'({cur_a, cur_b, cur_op, cur_out}), 0);
      check("rst_flags", int'({cur_z, cur_c, cur_valid, cur_busy}), 0);
      check("rst_cnt", int'(cur_cnt), 0);
    end
    sel = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(cur_ready), 1);

    run_vec(0);
    stall_en = 1'b1;
    for (int i = 1; i < 8; i++) run_vec(i);
    repeat (3) @(negedge clk);
    cnt_check("held_ack_idle");
    res_ack = 1'b0;

    sel = 1'b0;
    send_nib(4'h9);
    send_nib(4'h6);
    check("load_op_ready", int'(cur_ready), 1);
    pulse_reset("rst_load_op");
    run_op(4'h3, 4'h2, 4'd4, 4'h5, 1'b0, 1'b0, 2);
    pulse_reset("rst_hold");
    run_op(4'h3, 4'h2, 4'd4, 4'h5, 1'b0, 1'b0, 0);

    for (int i = 8; i < 12; i++) run_vec(i);
    check("wrap_count_zero", int'(cur_cnt), 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
